// File: rtl/nor_gate_tester_pkg.sv
// Shared constants and state type for the NOR gate tester.
// The tester walks all four 2-bit input vectors through an external gate.
package nor_gate_tester_pkg;

    localparam int NUM_VEC    = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    localparam int CNT_W = 4;
    localparam int IDX_W = 2;
    localparam int ERR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nor_gate_tester_norgate.sv
// Golden 2-input NOR used as the reference for the gate under test.
module norgate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = ~(a_i | b_i);

endmodule

// File: rtl/nor_gate_tester.sv
// Sequences vectors 00,01,10,11 into an external gate, samples its output after
// SETTLE cycles per vector and reports mismatches against a golden NOR.
//   state   | meaning
//   IDLE    | waiting for start, stimulus parked at 00, results held
//   RUN     | driving vector idx, counting down the settle window
//   DONE    | one-cycle done pulse, results final
module nor_gate_tester
    import nor_gate_tester_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               y_dut,
    output logic               a_out,
    output logic               b_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [NUM_VEC-1:0] fail_vec
);

    if ((SETTLE < SETTLE_MIN) || (SETTLE > SETTLE_MAX)) begin : g_settle_range
        $error("nor_gate_tester: SETTLE=%0d outside legal range %0d..%0d",
               SETTLE, SETTLE_MIN, SETTLE_MAX);
    end

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic                 pass_q, pass_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [NUM_VEC-1:0]   fail_q, fail_d;

    logic                 exp_y;
    logic                 sample;
    logic                 mismatch;

    norgate u_golden (
        .a_i (a_q),
        .b_i (b_q),
        .y_o (exp_y)
    );

    // The settle counter expires on the edge that closes each vector's window.
    assign sample   = (state_q == ST_RUN) && (cnt_q == '0);
    assign mismatch = sample && (y_dut != exp_y);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        unique case (state_q)
            ST_IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = SETTLE_LD;
                    idx_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end

            ST_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (mismatch) begin
                        fail_d[idx_q] = 1'b1;
                        err_d         = err_q + 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        // Includes the final vector's result folded in above.
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = SETTLE_LD;
                        a_d   = idx_d[1];
                        b_d   = idx_d[0];
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_nor_gate_tester.sv
// Bench for nor_gate_tester: the external gate is a truth table driven by the bench,
// and a timeline model (cycles since the accepting edge) predicts every output.
module tb_nor_gate_tester;

    localparam int SETTLE  = 2;
    localparam int P       = SETTLE + 1;
    localparam int RUN_LEN = 4 * P;

    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_STUCK = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] tt = TT_NOR;
    logic       y_dut;
    logic       a_out, b_out, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    int n_vec = 0;
    int n_err = 0;

    nor_gate_tester #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .y_dut     (y_dut),
        .a_out     (a_out),
        .b_out     (b_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    // Gate under test: output bit selected by {a,b} from the current truth table.
    assign y_dut = tt[{a_out, b_out}];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: t = cycles since the accepting edge; -1 after reset; RUN_LEN+1 when idle.
    int         t = -1;
    logic [3:0] tt_run = TT_NOR;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = -1;
        end else if (t < 0 || t > RUN_LEN) begin
            if (start) begin
                t      = 0;
                tt_run = tt;
            end
        end else begin
            t = t + 1;
        end
    end

    logic [3:0] m_full, m_fail;
    logic       m_a, m_b, m_busy, m_done, m_pass;
    int         m_k;

    always @(negedge clk) begin
        m_full = tt_run ^ TT_NOR;
        m_fail = 4'b0000;
        m_a = 1'b0; m_b = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
        if (t >= 0 && t < RUN_LEN) begin
            m_busy = 1'b1;
            m_k    = t / P;
            m_a    = ((m_k / 2) % 2) == 1;
            m_b    = (m_k % 2) == 1;
            for (int j = 0; j < 4; j++)
                if ((j + 1) * P <= t) m_fail[j] = m_full[j];
        end else if (t >= RUN_LEN) begin
            m_fail = m_full;
            m_pass = (m_full == 4'b0000);
            m_done = (t == RUN_LEN);
        end
        chk("a_out",     {7'b0, a_out}, {7'b0, m_a});
        chk("b_out",     {7'b0, b_out}, {7'b0, m_b});
        chk("busy",      {7'b0, busy},  {7'b0, m_busy});
        chk("done",      {7'b0, done},  {7'b0, m_done});
        chk("pass",      {7'b0, pass},  {7'b0, m_pass});
        chk("err_count", {5'b0, err_count}, 8'($countones(m_fail)));
        chk("fail_vec",  {4'b0, fail_vec},  {4'b0, m_fail});
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, " a/b"},  {6'b0, a_out, b_out}, 8'd0);
        chk({nm, " busy"}, {7'b0, busy}, 8'd0);
        chk({nm, " done"}, {7'b0, done}, 8'd0);
        chk({nm, " pass"}, {7'b0, pass}, 8'd0);
        chk({nm, " err"},  {5'b0, err_count}, 8'd0);
        chk({nm, " fail"}, {4'b0, fail_vec}, 8'd0);
    endtask

    task automatic run_dir(input string nm, input logic [3:0] gate, input bit repulse,
                           input logic [2:0] e_err, input logic [3:0] e_fail, input logic e_pass);
        int         dc;
        int         ndone;
        logic [7:0] seq;
        dc = -1; ndone = 0; seq = 8'h00;
        @(negedge clk);
        tt    = gate;
        start = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (dc < 0) dc = c;
            end
            if (c < 12 && (c % 3) == 1) seq[7 - 2 * (c / 3) -: 2] = {a_out, b_out};
            start = repulse && (c == 5);
        end
        chk({nm, " done_cycle"}, 8'(dc), 8'd12);
        chk({nm, " done_count"}, 8'(ndone), 8'd1);
        chk({nm, " ab_seq"}, seq, 8'b00_01_10_11);
        chk({nm, " err"},  {5'b0, err_count}, {5'b0, e_err});
        chk({nm, " fail"}, {4'b0, fail_vec},  {4'b0, e_fail});
        chk({nm, " pass"}, {7'b0, pass},      {7'b0, e_pass});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_dir("nor",    TT_NOR,   1'b0, 3'd0, 4'b0000, 1'b1);
        run_dir("or",     TT_OR,    1'b0, 3'd4, 4'b1111, 1'b0);
        run_dir("nand",   TT_NAND,  1'b0, 3'd2, 4'b0110, 1'b0);
        run_dir("stuck0", TT_STUCK, 1'b0, 3'd1, 4'b0001, 1'b0);
        run_dir("repulse_nand", TT_NAND, 1'b1, 3'd2, 4'b0110, 1'b0);

        // Reset asserted mid-run, between clock edges.
        @(negedge clk);
        tt    = TT_OR;
        start = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset busy", {7'b0, busy}, 8'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("no_autostart busy", {7'b0, busy}, 8'd0);
        end
        run_dir("post_reset_nor", TT_NOR, 1'b0, 3'd0, 4'b0000, 1'b1);

        // Held-high start: second run accepted on the first idle cycle.
        begin
            int first_dc, second_dc;
            first_dc = -1; second_dc = -1;
            @(negedge clk);
            tt    = TT_NAND;
            start = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    if (first_dc < 0) first_dc = c;
                    else if (second_dc < 0) second_dc = c;
                end
            end
            start = 1'b0;
            chk("held_start first_done",  8'(first_dc),  8'd12);
            chk("held_start second_done", 8'(second_dc), 8'd26);
            repeat (16) @(negedge clk);
        end

        // Randomized: truth tables, start traffic and occasional async resets.
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if ((t < 0 || t > RUN_LEN) && $urandom_range(0, 3) == 0) tt = 4'($urandom);
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #1 rst_n = 1'b0;
                #1 chk_all_zero("rand_reset");
                #1 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (16) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
